// File: rtl/flag_pkg.sv
// Shared constants for the flag unit: compare opcode, flag bit positions
// and default sizing used by the top level and the save stack.
package flag_pkg;

  localparam int OPW_DEF    = 5;
  localparam int NF_DEF     = 2;
  localparam int DEPTH_DEF  = 4;
  localparam int GT_BIT_DEF = 1;
  localparam int EQ_BIT_DEF = 0;

  localparam logic [4:0] CMP_OP_DEF = 5'b00101;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO used to save and restore the flag register across interrupts.
// The pointer wraps modulo DEPTH; the occupancy counter saturates at 0 and DEPTH.
// Simultaneous push and pop cancel out and leave the stack untouched.
module flag_stack
  import flag_pkg::*;
#(
  parameter int NF    = NF_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [NF-1:0] din,
  output logic [NF-1:0] dout,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  logic [NF-1:0] mem [DEPTH];
  logic [AW-1:0] sp_q, sp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;

  // Top of stack is the entry just below the write pointer.
  assign dout  = mem[sp_q - AW'(1)];
  assign cnt   = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  // Next pointer, occupancy and sticky error flags.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (do_push) begin
      sp_d  = sp_q + AW'(1);
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      sp_d  = sp_q - AW'(1);
      cnt_d = cnt_q - CW'(1);
    end
    if (push && !pop && full)  ovf_d = 1'b1;
    if (pop && !push && empty) unf_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage write; contents need no reset, a reset cycle drops the save.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[sp_q] <= din;
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural compare-flag register with same-cycle forwarding and an
// interrupt save/restore stack. Stall freezes everything; flush only
// squashes the flag update.
module flag_unit
  import flag_pkg::*;
#(
  parameter int             OPW    = OPW_DEF,
  parameter logic [OPW-1:0] CMP_OP = OPW'(CMP_OP_DEF),
  parameter int             NF     = NF_DEF,
  parameter int             GT_BIT = GT_BIT_DEF,
  parameter int             EQ_BIT = EQ_BIT_DEF,
  parameter int             DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPW-1:0]         op,
  input  logic                   valid_in,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NF-1:0]          flags_in,
  input  logic                   push,
  input  logic                   pop,
  output logic [NF-1:0]          flags_q,
  output logic [NF-1:0]          flags_fwd,
  output logic                   gt_flag,
  output logic                   eq_flag,
  output logic [$clog2(DEPTH):0] stack_cnt,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   ovf_err,
  output logic                   unf_err
);

  logic          upd;
  logic          push_g, pop_g;
  logic [NF-1:0] stack_dout;
  logic [NF-1:0] flags_d;

  assign upd    = valid_in & ~flush & ~stall & (op == CMP_OP);
  assign push_g = push & ~stall;
  assign pop_g  = pop & ~stall;

  assign flags_fwd = upd ? flags_in : flags_q;
  assign gt_flag   = flags_q[GT_BIT];
  assign eq_flag   = flags_q[EQ_BIT];

  flag_stack #(
    .NF    (NF),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_g),
    .pop   (pop_g),
    .din   (flags_q),
    .dout  (stack_dout),
    .cnt   (stack_cnt),
    .full  (stack_full),
    .empty (stack_empty),
    .ovf   (ovf_err),
    .unf   (unf_err)
  );

  // A lone pop owns the flag register (restore, or hold if nothing is saved);
  // otherwise a compare update lands.
  always_comb begin
    flags_d = flags_q;
    if (pop_g && !push_g) begin
      if (!stack_empty) flags_d = stack_dout;
    end else if (upd) begin
      flags_d = flags_in;
    end
  end

  // Flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_flag_unit;

  localparam logic [4:0] CMP = 5'b00101;
  localparam logic [4:0] NOP = 5'b00000;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, valid_in, stall, flush, push, pop;
  logic [4:0] op;
  logic [1:0] flags_in;
  logic [1:0] flags_q, flags_fwd;
  logic       gt_flag, eq_flag, stack_full, stack_empty, ovf_err, unf_err;
  logic [2:0] stack_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flag_unit dut (
    .clk(clk), .reset(reset), .op(op), .valid_in(valid_in), .stall(stall),
    .flush(flush), .flags_in(flags_in), .push(push), .pop(pop),
    .flags_q(flags_q), .flags_fwd(flags_fwd), .gt_flag(gt_flag), .eq_flag(eq_flag),
    .stack_cnt(stack_cnt), .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  typedef struct {
    bit         r;
    logic [4:0] o;
    bit         v, st, fl;
    logic [1:0] fi;
    bit         pu, po;
    logic [1:0] e_fwd, e_flags;
    int         e_cnt;
    bit         e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit r, logic [4:0] o, bit v, bit st, bit fl, logic [1:0] fi,
                     bit pu, bit po, logic [1:0] ef, logic [1:0] efl, int ec, bit eo, bit eu);
    vec_t t;
    t.r = r; t.o = o; t.v = v; t.st = st; t.fl = fl; t.fi = fi; t.pu = pu; t.po = po;
    t.e_fwd = ef; t.e_flags = efl; t.e_cnt = ec; t.e_ovf = eo; t.e_unf = eu;
    vecs.push_back(t);
  endtask

  task automatic chk(string name, int idx, int act, int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic drive(bit r, logic [4:0] o, bit v, bit st, bit fl, logic [1:0] fi, bit pu, bit po);
    reset = r; op = o; valid_in = v; stall = st; flush = fl; flags_in = fi; push = pu; pop = po;
  endtask

  // Apply one cycle: fwd checked before the edge, state checked after it.
  task automatic apply(int idx, bit r, logic [4:0] o, bit v, bit st, bit fl, logic [1:0] fi,
                       bit pu, bit po, logic [1:0] ef, logic [1:0] efl, int ec, bit eo, bit eu);
    @(negedge clk);
    drive(r, o, v, st, fl, fi, pu, po);
    #1;
    if (!r) chk("flags_fwd", idx, int'(flags_fwd), int'(ef));
    @(posedge clk);
    #1;
    n_vec++;
    chk("flags_q", idx, int'(flags_q), int'(efl));
    chk("gt_flag", idx, int'(gt_flag), int'(efl[1]));
    chk("eq_flag", idx, int'(eq_flag), int'(efl[0]));
    chk("stack_cnt", idx, int'(stack_cnt), ec);
    chk("stack_full", idx, int'(stack_full), int'(ec == DEPTH));
    chk("stack_empty", idx, int'(stack_empty), int'(ec == 0));
    chk("ovf_err", idx, int'(ovf_err), int'(eo));
    chk("unf_err", idx, int'(unf_err), int'(eu));
    $display("vec %0d rst=%0b op=%02h v=%0b st=%0b fl=%0b fi=%02b pu=%0b po=%0b -> flags=%02b cnt=%0d ovf=%0b unf=%0b",
             idx, r, o, v, st, fl, fi, pu, po, flags_q, stack_cnt, ovf_err, unf_err);
  endtask

  // Reference model state.
  logic [1:0] m_flags;
  logic [1:0] m_stack[$];
  bit         m_ovf, m_unf;

  initial begin
    drive(1, NOP, 0, 0, 0, 2'b00, 0, 0);

    //   r  op  v st fl fi     pu po  fwd    flags  cnt ovf unf
    add(1, NOP, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b10, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    add(0, CMP, 1, 0, 1, 2'b01, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    add(0, CMP, 1, 1, 0, 2'b01, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    add(0, NOP, 1, 0, 0, 2'b11, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    add(0, CMP, 0, 0, 0, 2'b01, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b01, 0, 0, 2'b01, 2'b01, 0, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b01, 2'b01, 1, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b10, 0, 0, 2'b10, 2'b10, 1, 0, 0);
    add(0, NOP, 0, 1, 0, 2'b00, 0, 1, 2'b10, 2'b10, 1, 0, 0);
    add(0, NOP, 0, 0, 1, 2'b00, 0, 1, 2'b10, 2'b01, 0, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b01, 2'b01, 0, 0, 1);
    add(0, CMP, 1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 1);
    add(0, CMP, 1, 0, 0, 2'b11, 0, 1, 2'b11, 2'b00, 0, 0, 1);
    add(1, NOP, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b01, 1, 0, 2'b01, 2'b01, 1, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b10, 1, 0, 2'b10, 2'b10, 2, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b10, 2'b10, 3, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b10, 2'b10, 4, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b10, 2'b10, 4, 1, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b10, 2'b10, 3, 1, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b10, 2'b10, 2, 1, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b01, 2'b00, 0, 1, 0);
    add(1, NOP, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 2, 0, 0);
    add(0, CMP, 1, 0, 0, 2'b11, 1, 1, 2'b11, 2'b11, 2, 0, 0);
    add(0, NOP, 0, 0, 0, 2'b00, 0, 1, 2'b11, 2'b00, 1, 0, 0);
    add(1, NOP, 0, 0, 0, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0);

    foreach (vecs[i])
      apply(i, vecs[i].r, vecs[i].o, vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].fi,
            vecs[i].pu, vecs[i].po, vecs[i].e_fwd, vecs[i].e_flags, vecs[i].e_cnt,
            vecs[i].e_ovf, vecs[i].e_unf);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit         r, v, st, fl, pu, po, upd;
      logic [4:0] o;
      logic [1:0] fi, efwd;
      r  = (i == 0) || ($urandom_range(0, 59) == 0);
      o  = ($urandom_range(0, 9) < 6) ? CMP : 5'($urandom);
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 9) < 2);
      fi = 2'($urandom);
      pu = ($urandom_range(0, 9) < 3);
      po = ($urandom_range(0, 9) < 3);

      upd  = v && !fl && !st && (o == CMP);
      efwd = upd ? fi : m_flags;

      if (r) begin
        m_flags = 2'b00; m_stack.delete(); m_ovf = 0; m_unf = 0;
      end else if (!st) begin
        if (po && !pu) begin
          if (m_stack.size() == 0) m_unf = 1;
          else m_flags = m_stack.pop_back();
        end else begin
          if (pu && !po) begin
            if (m_stack.size() == DEPTH) m_ovf = 1;
            else m_stack.push_back(m_flags);
          end
          if (upd) m_flags = fi;
        end
      end

      apply(1000 + i, r, o, v, st, fl, fi, pu, po, efwd, m_flags, m_stack.size(), m_ovf, m_unf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL take parameter OPW, default 5, giving the opcode width.
REQ-002 SHALL take parameter CMP_OP, default 5'b00101, the opcode that updates flags.
REQ-003 SHALL take parameter NF, default 2, giving the flag vector width (NF >= 2).
REQ-004 SHALL take parameter GT_BIT, default 1, the index of the GT flag in the flag vector.
REQ-005 SHALL take parameter EQ_BIT, default 0, the index of the EQ flag in the flag vector.
REQ-006 SHALL take parameter DEPTH, default 4, giving the flag-save stack depth (power of 2, >= 2).
REQ-007 SHALL have clock and reset as follows: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-008 Ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  OPW  opcode of the instruction in the execute stage
- valid_in  in  1  op/flags_in qualify this cycle
- stall  in  1  pipeline stall; freezes all state
- flush  in  1  squash the current instruction
- flags_in  in  NF  ALU compare result
- push  in  1  save flags (interrupt entry)
- pop  in  1  restore flags (interrupt return)
- flags_q  out  NF  architectural flag register
- flags_fwd  out  NF  bypassed flags for a same-cycle branch
- gt_flag  out  1  flags_q[GT_BIT]
- eq_flag  out  1  flags_q[EQ_BIT]
- stack_cnt  out  log2(DEPTH)+1  number of saved entries
- stack_full  out  1  stack_cnt == DEPTH
- stack_empty  out  1  stack_cnt == 0
- ovf_err  out  1  sticky overflow flag
- unf_err  out  1  sticky underflow flag

Function
REQ-009 SHALL define upd = valid_in & !flush & !stall & (op == CMP_OP).
REQ-010 SHALL load flags_in into flags_q at the next clk edge when upd is set; otherwise flags_q SHALL hold, which replaces the previous latch-style retention with a true register.
REQ-011 SHALL drive flags_fwd combinationally as upd ? flags_in : flags_q, with zero latency.
REQ-012 SHALL drive gt_flag and eq_flag combinationally from flags_q, adding no extra delay.
REQ-013 When stall is set, SHALL ignore push, pop and update, so all state holds.
REQ-014 On a push when the stack is not full, SHALL store the pre-update flags_q at the top and increment stack_cnt by 1; any same-cycle upd SHALL still update flags_q.
REQ-015 On a pop when the stack is not empty, SHALL load the top entry into flags_q and decrement stack_cnt; pop SHALL take priority over a same-cycle upd, whose value is discarded.
REQ-016 On a push when the stack is full, SHALL leave the stack and stack_cnt unchanged and set ovf_err.
REQ-017 On a pop when the stack is empty, SHALL leave flags_q and stack_cnt unchanged and set unf_err.
REQ-018 On push and pop in the same cycle, SHALL leave the stack unchanged, set no error, and let upd apply normally.
REQ-019 ovf_err and unf_err SHALL remain set until reset.
REQ-020 flush SHALL suppress only the update; push and pop SHALL remain effective under flush.
REQ-021 Stack pointer arithmetic SHALL be modulo DEPTH; stack_cnt SHALL saturate at both 0 and DEPTH.

Reset
REQ-022 On reset, SHALL set flags_q to 0, stack_cnt to 0, stack_empty to 1, stack_full to 0, ovf_err to 0 and unf_err to 0.
REQ-023 Reset SHALL take precedence over stall, push, pop and upd in the same cycle, and SHALL abandon any in-flight save or restore.
REQ-024 Stack storage contents SHALL not require a reset; they are unobservable while stack_cnt is 0.

Structure
REQ-025 A shared package flag_pkg SHALL hold the CMP opcode constant, the GT/EQ bit indices and the default NF, OPW and DEPTH values.
REQ-026 The LIFO SHALL be a sub-module flag_stack (parameters NF and DEPTH; ports push, pop, din, dout, cnt, full, empty, ovf, unf), instantiated once.

Verification
REQ-027 Reset then op=5'b00101, valid_in=1, flags_in=2'b10 -> flags_fwd=2'b10 in the same cycle; next cycle gt_flag=1, eq_flag=0.
REQ-028 CMP with flags_in=2'b01 while flush=1 or stall=1 -> flags_q unchanged at 2'b10; a non-CMP op with flags_in=2'b11 -> flags_q unchanged.
REQ-029 With flags_q=2'b01: push, then CMP 2'b10, then pop -> stack_cnt goes 1 then 0, and flags_q ends at 2'b01.
REQ-030 Five pushes with DEPTH=4 -> stack_full=1 after the fourth push, ovf_err=1 after the fifth, and stack_cnt stays at 4.
REQ-031 Pop on an empty stack -> unf_err=1 and flags_q unchanged; a pop concurrent with CMP 2'b11 after a saved 2'b00 -> flags_q=2'b00.
REQ-032 push+pop in the same cycle with stack_cnt=2 -> stack_cnt stays 2 and no error is set; reset asserted during a push -> stack_cnt=0 next cycle.
